// File: rtl/i2s_master_ctrl.sv
// I2S/TDM master clock generator: derives bclk and lrck from clk using a
// configuration latched at every frame start.
module i2s_master_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [7:0]  i_bclk_div,
    input  logic [4:0]  i_tdm_num,
    input  logic [5:0]  i_word_width,
    input  logic        i_lrck_mode,
    input  logic        i_lrck_invert,
    output logic        bclk,
    output logic        lrck,
    output logic        o_busy,
    output logic        o_frame_start,
    output logic [31:0] o_frame_num
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [9:0]  bit_cnt_q, bit_cnt_d;
    logic        bclk_q, bclk_d;
    logic        lrck_q, lrck_d;
    logic        fs_q, fs_d;
    logic [31:0] frame_num_q, frame_num_d;
    logic [4:0]  n_q, n_d;
    logic [5:0]  w_q, w_d;
    logic [7:0]  div_q, div_d;
    logic        mode_q, mode_d;
    logic        inv_q, inv_d;

    logic [4:0]  n_clamp;
    logic [5:0]  w_clamp;
    logic [9:0]  frame_len;
    logic [9:0]  next_bit;
    logic        next_active;
    logic        start_frame;

    always_comb begin
        n_clamp = i_tdm_num;
        if (i_tdm_num == 5'd0) begin
            n_clamp = 5'd1;
        end else if (i_tdm_num > 5'd16) begin
            n_clamp = 5'd16;
        end
        w_clamp = i_word_width;
        if (i_word_width < 6'd8) begin
            w_clamp = 6'd8;
        end else if (i_word_width > 6'd32) begin
            w_clamp = 6'd32;
        end
    end

    assign frame_len   = {5'd0, n_q} * {4'd0, w_q};
    assign next_bit    = bit_cnt_q + 10'd1;
    assign next_active = mode_q ? (next_bit == 10'd0) : (next_bit < (frame_len >> 1));

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        fs_d        = 1'b0;
        frame_num_d = frame_num_q;
        n_d         = n_q;
        w_d         = w_q;
        div_d       = div_q;
        mode_d      = mode_q;
        inv_d       = inv_q;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                bclk_d    = 1'b0;
                if (i_enable) begin
                    start_frame = 1'b1;
                end
            end
            RUN: begin
                if (div_cnt_q == div_q) begin
                    div_cnt_d = '0;
                    bclk_d    = ~bclk_q;
                    // Bit/slot state only moves on the bclk falling toggle.
                    if (bclk_q) begin
                        if (bit_cnt_q == frame_len - 10'd1) begin
                            if (i_enable) begin
                                start_frame = 1'b1;
                            end else begin
                                state_d   = IDLE;
                                bit_cnt_d = '0;
                            end
                        end else begin
                            bit_cnt_d = next_bit;
                            lrck_d    = next_active ^ inv_q;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bit 0 is always in the active phase, in both lrck modes.
        if (start_frame) begin
            state_d     = RUN;
            n_d         = n_clamp;
            w_d         = w_clamp;
            div_d       = i_bclk_div;
            mode_d      = i_lrck_mode;
            inv_d       = i_lrck_invert;
            div_cnt_d   = '0;
            bit_cnt_d   = '0;
            bclk_d      = 1'b0;
            lrck_d      = ~i_lrck_invert;
            fs_d        = 1'b1;
            frame_num_d = frame_num_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            fs_q        <= 1'b0;
            frame_num_q <= '0;
            n_q         <= '0;
            w_q         <= '0;
            div_q       <= '0;
            mode_q      <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            fs_q        <= fs_d;
            frame_num_q <= frame_num_d;
            n_q         <= n_d;
            w_q         <= w_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            inv_q       <= inv_d;
        end
    end

    assign bclk          = bclk_q;
    assign lrck          = (state_q == RUN) ? lrck_q : i_lrck_invert;
    assign o_busy        = (state_q == RUN);
    assign o_frame_start = fs_q;
    assign o_frame_num   = frame_num_q;

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Scenario bench for i2s_master_ctrl against a timeline model that derives
// bclk/lrck from elapsed clk cycles since the frame start.
module tb_i2s_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [7:0]  i_bclk_div;
    logic [4:0]  i_tdm_num;
    logic [5:0]  i_word_width;
    logic        i_lrck_mode;
    logic        i_lrck_invert;
    logic        bclk;
    logic        lrck;
    logic        o_busy;
    logic        o_frame_start;
    logic [31:0] o_frame_num;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: running flag, clk cycles since frame start, latched config.
    int          m_run, m_t, m_n, m_w, m_half, m_mode, m_inv;
    logic [31:0] m_num;

    i2s_master_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_bclk_div   (i_bclk_div),
        .i_tdm_num    (i_tdm_num),
        .i_word_width (i_word_width),
        .i_lrck_mode  (i_lrck_mode),
        .i_lrck_invert(i_lrck_invert),
        .bclk         (bclk),
        .lrck         (lrck),
        .o_busy       (o_busy),
        .o_frame_start(o_frame_start),
        .o_frame_num  (o_frame_num)
    );

    always #5 clk = ~clk;

    task automatic model_latch;
        int n;
        int w;
        n = int'(i_tdm_num);
        w = int'(i_word_width);
        m_n    = (n == 0) ? 1 : ((n > 16) ? 16 : n);
        m_w    = (w < 8) ? 8 : ((w > 32) ? 32 : w);
        m_half = int'(i_bclk_div) + 1;
        m_mode = int'(i_lrck_mode);
        m_inv  = int'(i_lrck_invert);
    endtask

    task automatic model_step;
        if (rst) begin
            m_run = 0; m_t = 0; m_num = '0;
            m_n = 0; m_w = 0; m_half = 1; m_mode = 0; m_inv = 0;
        end else if (m_run == 0) begin
            if (i_enable) begin
                m_run = 1; m_t = 0; m_num = m_num + 32'd1;
                model_latch();
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == m_n * m_w * 2 * m_half) begin
                if (i_enable) begin
                    m_t = 0; m_num = m_num + 32'd1;
                    model_latch();
                end else begin
                    m_run = 0;
                end
            end
        end
    endtask

    function automatic logic [35:0] model_out();
        int  b;
        int  f;
        logic act;
        logic bc;
        if (m_run == 0) return {1'b0, i_lrck_invert, 1'b0, 1'b0, m_num};
        f   = m_n * m_w;
        b   = m_t / (2 * m_half);
        bc  = ((m_t / m_half) % 2) == 1;
        act = (m_mode != 0) ? (b == 0) : (b < f / 2);
        return {bc, act ^ (m_inv != 0), 1'b1, (m_t == 0), m_num};
    endfunction

    function automatic logic [35:0] dut_out();
        return {bclk, lrck, o_busy, o_frame_start, o_frame_num};
    endfunction

    task automatic tick;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_cfg(input logic [7:0] d, input logic [4:0] n, input logic [5:0] w,
                           input logic m, input logic v);
        i_bclk_div = d; i_tdm_num = n; i_word_width = w; i_lrck_mode = m; i_lrck_invert = v;
    endtask

    task automatic do_reset;
        i_enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        set_cfg(8'd1, 5'd2, 6'd16, 1'b0, 1'b0);
        i_enable = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (dut_out() !== 36'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_out(), 36'd0);
        end
        i_enable = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=%h", dut_out(), model_out());
        end
        i_lrck_invert = 1'b1;
        #1;
        checks++;
        if (lrck !== 1'b1) begin
            errors++;
            $display("FAIL idle_lrck_follow got=%b exp=1", lrck);
        end
    endtask

    task automatic test_i2s_stereo;
        int nfs;
        int last;
        set_cfg(8'd1, 5'd2, 6'd16, 1'b0, 1'b0);
        do_reset();
        i_enable = 1'b1;
        nfs = 0;
        last = -1;
        for (int i = 0; i < 600 && nfs < 3; i++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL i2s_cycle cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
            end
            if (o_frame_start) begin
                nfs++;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 128) begin
                        errors++;
                        $display("FAIL i2s_frame_period got=%0d exp=128", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        checks++;
        if (nfs != 3 || o_frame_num !== 32'd3) begin
            errors++;
            $display("FAIL i2s_frame_num starts=%0d got=%0d exp=3", nfs, o_frame_num);
        end
    endtask

    task automatic test_tdm;
        int   low_len;
        int   last_low;
        logic p_lrck;
        logic p_bclk;
        logic p_busy;
        set_cfg(8'd0, 5'd8, 6'd32, 1'b1, 1'b1);
        do_reset();
        i_enable = 1'b1;
        low_len = 0;
        last_low = -1;
        p_lrck = lrck; p_bclk = bclk; p_busy = o_busy;
        for (int i = 0; i < 1100; i++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL tdm_cycle cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
            end
            if (p_busy && lrck !== p_lrck) begin
                checks++;
                if (!(p_bclk === 1'b1 && bclk === 1'b0)) begin
                    errors++;
                    $display("FAIL tdm_lrck_edge cyc=%0d bclk %b->%b exp 1->0", cyc, p_bclk, bclk);
                end
            end
            if (lrck === 1'b0 && p_lrck === 1'b1) begin
                if (last_low >= 0) begin
                    checks++;
                    if (cyc - last_low != 512) begin
                        errors++;
                        $display("FAIL tdm_pulse_spacing got=%0d exp=512", cyc - last_low);
                    end
                end
                last_low = cyc;
            end
            if (lrck === 1'b0) begin
                low_len++;
            end else if (low_len > 0) begin
                checks++;
                if (low_len != 2) begin
                    errors++;
                    $display("FAIL tdm_pulse_width got=%0d exp=2", low_len);
                end
                low_len = 0;
            end
            p_lrck = lrck; p_bclk = bclk; p_busy = o_busy;
        end
    endtask

    task automatic test_stop_restart;
        int cnt;
        set_cfg(8'd1, 5'd2, 6'd16, 1'b0, 1'b0);
        do_reset();
        i_enable = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) tick();
        i_enable = 1'b0;
        cnt = 0;
        while (o_busy && cnt < 500) begin
            tick();
            cnt++;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL stop_cycle cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
            end
        end
        checks++;
        if (cnt != 88 || bclk !== 1'b0 || lrck !== 1'b0) begin
            errors++;
            $display("FAIL stop_boundary cycles=%0d bclk=%b lrck=%b exp cycles=88 bclk=0 lrck=0",
                     cnt, bclk, lrck);
        end
        for (int i = 0; i < 3; i++) tick();
        i_enable = 1'b1;
        tick();
        checks++;
        if (o_frame_start !== 1'b1 || o_busy !== 1'b1 || o_frame_num !== 32'd2) begin
            errors++;
            $display("FAIL restart fs=%b busy=%b num=%0d exp fs=1 busy=1 num=2",
                     o_frame_start, o_busy, o_frame_num);
        end
    endtask

    task automatic test_config_change;
        int start;
        int exp_len[2];
        exp_len[0] = 64;
        exp_len[1] = 96;
        set_cfg(8'd0, 5'd2, 6'd16, 1'b0, 1'b0);
        do_reset();
        i_enable = 1'b1;
        tick();
        start = cyc;
        for (int i = 0; i < 10; i++) tick();
        i_word_width = 6'd24;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 400; i++) begin
                tick();
                checks++;
                if (dut_out() !== model_out()) begin
                    errors++;
                    $display("FAIL cfgchg_cycle cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
                end
                if (o_frame_start) break;
            end
            checks++;
            if (o_frame_start !== 1'b1 || cyc - start != exp_len[k]) begin
                errors++;
                $display("FAIL cfgchg_frame%0d len got=%0d exp=%0d", k, cyc - start, exp_len[k]);
            end
            start = cyc;
        end
    endtask

    task automatic test_clamping;
        logic [4:0] tn[3];
        logic [5:0] ww[3];
        int         exp_len[3];
        tn[0] = 5'd1; ww[0] = 6'd40; exp_len[0] = 64;
        tn[1] = 5'd0; ww[1] = 6'd16; exp_len[1] = 32;
        tn[2] = 5'd1; ww[2] = 6'd4;  exp_len[2] = 16;
        for (int k = 0; k < 3; k++) begin
            int start;
            set_cfg(8'd0, tn[k], ww[k], 1'b0, 1'b0);
            do_reset();
            i_enable = 1'b1;
            tick();
            start = cyc;
            for (int i = 0; i < 200; i++) begin
                tick();
                checks++;
                if (dut_out() !== model_out()) begin
                    errors++;
                    $display("FAIL clamp_cycle cyc=%0d got=%h exp=%h", cyc, dut_out(), model_out());
                end
                if (o_frame_start) break;
            end
            checks++;
            if (o_frame_start !== 1'b1 || cyc - start != exp_len[k]) begin
                errors++;
                $display("FAIL clamp_case%0d len got=%0d exp=%0d", k, cyc - start, exp_len[k]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        set_cfg(8'd1, 5'd2, 6'd16, 1'b0, 1'b0);
        do_reset();
        i_enable = 1'b1;
        tick();
        for (int i = 0; i < 80; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (dut_out() !== 36'd0) begin
            errors++;
            $display("FAIL rst_mid got=%h exp=%h", dut_out(), 36'd0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b1 || o_frame_start !== 1'b1 || o_frame_num !== 32'd1 || bclk !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart busy=%b fs=%b num=%0d bclk=%b exp 1 1 1 0",
                     o_busy, o_frame_start, o_frame_num, bclk);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            set_cfg(8'($urandom_range(0, 3)), 5'($urandom_range(0, 4)), 6'($urandom_range(4, 40)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            do_reset();
            i_enable = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 199) == 0) i_enable = ~i_enable;
                if ($urandom_range(0, 99) == 0)
                    set_cfg(8'($urandom_range(0, 3)), 5'($urandom_range(0, 4)),
                            6'($urandom_range(4, 40)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
                rst = ($urandom_range(0, 499) == 0);
                tick();
                checks++;
                if (dut_out() !== model_out()) begin
                    errors++;
                    $display("FAIL random_cycle round=%0d cyc=%0d got=%h exp=%h",
                             r, cyc, dut_out(), model_out());
                end
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        i_enable = 1'b0;
        set_cfg(8'd0, 5'd1, 6'd8, 1'b0, 1'b0);
        test_reset();
        test_i2s_stereo();
        test_tdm();
        test_stop_restart();
        test_config_change();
        test_clamping();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_master_ctrl.md
I2S_MASTER_CTRL -- requirements
Module: i2s_master_ctrl

Interface
REQ-001 Clocking and reset SHALL be one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-002 clk  input  1  system clock; all logic runs on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i_enable  input  1  run request; 1 starts or continues frames, 0 stops at the next frame boundary.
REQ-005 i_bclk_div  input  8  bclk half-period in clk cycles, minus 1; 0 gives bclk = clk/2.
REQ-006 i_tdm_num  input  5  slots per frame; legal range 1..16.
REQ-007 i_word_width  input  6  bits per slot; legal range 8..32.
REQ-008 i_lrck_mode  input  1  frame-sync shape: 0 = 50% duty (I2S), 1 = one-bclk pulse (TDM).
REQ-009 i_lrck_invert  input  1  0: lrck active level is high; 1: active level is low.
REQ-010 bclk  output  1  generated bit clock.
REQ-011 lrck  output  1  generated frame clock.
REQ-012 o_busy  output  1  high while the state is RUN.
REQ-013 o_frame_start  output  1  one-clk pulse when a frame begins.
REQ-014 o_frame_num  output  32  count of frames started since reset.

Function
REQ-015 States SHALL be IDLE and RUN only. Reset state is IDLE.
REQ-016 IDLE outputs SHALL be: bclk=0, lrck=i_lrck_invert (inactive level), divider counter held at 0.
REQ-017 IDLE->RUN SHALL occur in the cycle after i_enable=1 is sampled. That cycle also:
- latches the configuration;
- drives lrck to its first-bit value;
- pulses o_frame_start;
- keeps bclk=0.
REQ-018 Divider in RUN: 8-bit counter counts 0..div_latched; at div_latched it wraps to 0 and bclk toggles. bclk period = 2*(div_latched+1) clk.
REQ-019 All bit/slot counter updates and lrck changes SHALL happen only in the clk cycle where bclk toggles 1->0, and at RUN entry. lrck is never changed on a bclk rising edge.
REQ-020 Frame bit counter (10-bit) SHALL run 0..F-1, where F = N*W with N, W the latched slot count and width. It advances once per bclk falling toggle and wraps at F-1.
REQ-021 Clamping SHALL be applied when latching: N = 1 if i_tdm_num = 0, 16 if i_tdm_num > 16. W = 8 if i_word_width < 8, 32 if i_word_width > 32.
REQ-022 Mode 0: lrck SHALL be at active level for frame bits 0..floor(F/2)-1 and inactive otherwise.
REQ-023 Mode 1: lrck SHALL be at active level for frame bit 0 only.
REQ-024 Frame boundary is the falling toggle at which the frame bit counter wraps F-1 -> 0. At the boundary:
- if i_enable=1: re-latch configuration (new N, W, div, mode, invert take effect from bit 0), pulse o_frame_start, continue RUN;
- if i_enable=0: enter IDLE in the same cycle with bclk=0 and lrck inactive; no o_frame_start.
REQ-025 Configuration changes mid-frame SHALL have no effect until the next boundary. Deasserting i_enable mid-frame SHALL NOT truncate the frame.
REQ-026 Re-asserting i_enable before the boundary SHALL continue without a gap.
REQ-027 o_frame_num SHALL increment by 1 in the same cycle as each o_frame_start pulse and wrap from 0xFFFFFFFF to 0.
REQ-028 o_busy SHALL be 1 exactly in RUN, including the RUN entry cycle.
REQ-029 The frame-start bclk falling edge is the RUN entry cycle or the boundary cycle. The first bclk rising edge after it samples slot 0 bit 0 (MSB).

Reset
REQ-030 rst=1 SHALL, at the next clk edge and regardless of state:
- force IDLE;
- set bclk=0, lrck=0, o_frame_start=0, o_busy=0, o_frame_num=0;
- clear all counters and latched configuration to 0.
REQ-031 After reset, the configuration is unlatched, so lrck in IDLE SHALL follow i_lrck_invert combinationally.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no completion.

Verification
REQ-033 I2S stereo: div=1, N=2, W=16, mode=0, invert=0, enable=1.
- bclk period 4 clk.
- lrck high for 16 bclk, then low for 16 bclk.
- o_frame_start every 128 clk.
- o_frame_num = 3 after three frame starts.
REQ-034 TDM: div=0, N=8, W=32, mode=1, invert=1.
- lrck low for exactly 1 bclk period (2 clk) every 256 bclk.
- lrck changes only on bclk falling edges.
REQ-035 Stop/restart:
- deassert enable at frame bit 10 -> frame completes to bit F-1, then IDLE with bclk=0 and lrck inactive; o_busy falls at the boundary;
- reassert enable -> o_frame_start one cycle later.
REQ-036 Mid-frame config change: W changes 16->24 at bit 5 -> current frame stays 32 bits; the next frame is 48 bits.
REQ-037 Clamping:
- i_word_width=40 behaves as 32;
- i_tdm_num=0 behaves as 1;
- i_word_width=4 behaves as 8.
REQ-038 Reset mid-frame: rst pulse at bit 20 -> next cycle bclk=0, lrck=0, o_frame_num=0, o_busy=0. With enable held at 1, RUN restarts one cycle after rst deasserts.
